// File: rtl/spike_row_tx.sv
// Row-framing transmitter: wraps each upstream spike row in zero pads and streams it to the delay-line buffer.
// Define SPIKE_ROW_TX_FLUSH_EN to append DEPTH+1 zero flush words after the last row of a frame.

// state   | meaning
// IDLE    | waiting for START, config latched on START
// PAD_L   | emitting left pad zeros of the current row
// DATA    | accepting upstream words and forwarding them
// PAD_R   | emitting right pad zeros of the current row
// FLUSH   | emitting zero words to drain the delay line

module spike_row_tx #(
   parameter int WIDTH = 48,
   parameter int CW    = 9
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [CW-1:0]    ROW_LEN,
   input  logic [CW-1:0]    NUM_ROWS,
   input  logic [1:0]       PAD,
   input  logic [CW-1:0]    DEPTH,
   input  logic             IN_VALID,
   input  logic [WIDTH-1:0] IN_D,
   output logic             IN_READY,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] OUT_D,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PAD_L = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAD_R = 3'd3;
`ifdef SPIKE_ROW_TX_FLUSH_EN
   localparam logic [2:0] S_FLUSH = 3'd4;
`endif

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [2:0]    state;
   logic [CW-1:0] row_len_q;
   logic [CW-1:0] num_rows_q;
   logic [1:0]    pad_q;
   logic [CW-1:0] col_cnt;
   logic [CW-1:0] row_cnt;
   logic [1:0]    pad_cnt;

`ifdef SPIKE_ROW_TX_FLUSH_EN
   logic [CW-1:0] depth_q;
   logic [CW-1:0] flush_cnt;
`else
   logic          unused_depth;
   assign unused_depth = ^DEPTH;
`endif

   logic          col_last;
   logic          row_last;
   logic          pad_last;
   logic [2:0]    row_start_state;
   logic [2:0]    row_end_state;
   logic          row_end_done;

   assign IN_READY = (state == S_DATA);
   assign BUSY     = (state != S_IDLE);

   assign col_last = (col_cnt == row_len_q);
   assign row_last = (row_cnt == num_rows_q);
   // Only evaluated in PAD_L/PAD_R, where pad_q is non-zero.
   assign pad_last = (pad_cnt == (pad_q - 2'd1));

   always_comb begin
      row_start_state = (pad_q != 2'd0) ? S_PAD_L : S_DATA;
      row_end_state   = row_start_state;
      row_end_done    = 1'b0;
      if (row_last) begin
`ifdef SPIKE_ROW_TX_FLUSH_EN
         row_end_state = S_FLUSH;
         row_end_done  = 1'b0;
`else
         row_end_state = S_IDLE;
         row_end_done  = 1'b1;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         row_len_q  <= '0;
         num_rows_q <= '0;
         pad_q      <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         pad_cnt    <= '0;
         OUT_VALID  <= 1'b0;
         OUT_D      <= '0;
         DONE       <= 1'b0;
`ifdef SPIKE_ROW_TX_FLUSH_EN
         depth_q    <= '0;
         flush_cnt  <= '0;
`endif
      end else begin
         OUT_VALID <= 1'b0;
         DONE      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  row_len_q  <= ROW_LEN;
                  num_rows_q <= NUM_ROWS;
                  pad_q      <= PAD;
                  col_cnt    <= '0;
                  row_cnt    <= '0;
                  pad_cnt    <= '0;
`ifdef SPIKE_ROW_TX_FLUSH_EN
                  depth_q    <= DEPTH;
                  flush_cnt  <= '0;
`endif
                  state      <= (PAD != 2'd0) ? S_PAD_L : S_DATA;
               end
            end

            S_PAD_L: begin
               OUT_VALID <= 1'b1;
               OUT_D     <= '0;
               if (pad_last) begin
                  pad_cnt <= '0;
                  state   <= S_DATA;
               end else begin
                  pad_cnt <= pad_cnt + 2'd1;
               end
            end

            S_DATA: begin
               if (IN_VALID && IN_READY) begin
                  OUT_VALID <= 1'b1;
                  OUT_D     <= IN_D;
                  if (col_last) begin
                     col_cnt <= '0;
                     if (pad_q != 2'd0) begin
                        state <= S_PAD_R;
                     end else begin
                        state <= row_end_state;
                        DONE  <= row_end_done;
                        if (!row_last) row_cnt <= row_cnt + CNT_ONE;
                     end
                  end else begin
                     col_cnt <= col_cnt + CNT_ONE;
                  end
               end
            end

            S_PAD_R: begin
               OUT_VALID <= 1'b1;
               OUT_D     <= '0;
               if (pad_last) begin
                  pad_cnt <= '0;
                  state   <= row_end_state;
                  DONE    <= row_end_done;
                  if (!row_last) row_cnt <= row_cnt + CNT_ONE;
               end else begin
                  pad_cnt <= pad_cnt + 2'd1;
               end
            end

`ifdef SPIKE_ROW_TX_FLUSH_EN
            S_FLUSH: begin
               OUT_VALID <= 1'b1;
               OUT_D     <= '0;
               if (flush_cnt == depth_q) begin
                  flush_cnt <= '0;
                  state     <= S_IDLE;
                  DONE      <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt + CNT_ONE;
               end
            end
`endif

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_row_tx.sv
// Bench for spike_row_tx: table of frame configs checked against a word-stream model, plus stall and reset sequences.
// Follows SPIKE_ROW_TX_FLUSH_EN the same way the design does.

module tb_spike_row_tx;
   localparam int WIDTH = 48;
   localparam int CW    = 9;

   logic             CLK = 1'b0;
   logic             RST;
   logic             START;
   logic [CW-1:0]    ROW_LEN;
   logic [CW-1:0]    NUM_ROWS;
   logic [1:0]       PAD;
   logic [CW-1:0]    DEPTH;
   logic             IN_VALID;
   logic [WIDTH-1:0] IN_D;
   logic             IN_READY;
   logic             OUT_VALID;
   logic [WIDTH-1:0] OUT_D;
   logic             BUSY;
   logic             DONE;

   spike_row_tx #(.WIDTH(WIDTH), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS),
      .PAD(PAD), .DEPTH(DEPTH), .IN_VALID(IN_VALID), .IN_D(IN_D), .IN_READY(IN_READY),
      .OUT_VALID(OUT_VALID), .OUT_D(OUT_D), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int row_len;
      int num_rows;
      int pad;
      int depth;
      int rand_valid;
      int seq_data;
      int mid_start;
      int exp_row_words;
   } vec_t;

   vec_t vecs[7];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[WIDTH-1:0];
   endfunction

   function automatic int flush_words(input int depth);
`ifdef SPIKE_ROW_TX_FLUSH_EN
      return depth + 1;
`else
      return 0;
`endif
   endfunction

   // Starts at a negedge with the DUT idle; returns at the negedge showing DONE.
   task automatic run_frame(input vec_t v);
      logic [WIDTH-1:0] exp_q[$];
      logic [WIDTH-1:0] src_q[$];
      logic [WIDTH-1:0] w;
      int n_data = 0;
      int exp_total, budget;
      int cyc = 0, first = -1, seen = 0, ready_cyc = 0;
      bit done = 0;

      for (int r = 0; r <= v.num_rows; r++) begin
         for (int p = 0; p < v.pad; p++) exp_q.push_back('0);
         for (int c = 0; c <= v.row_len; c++) begin
            w = v.seq_data != 0 ? WIDTH'(n_data + 1) : rand_word();
            src_q.push_back(w);
            exp_q.push_back(w);
            n_data++;
         end
         for (int p = 0; p < v.pad; p++) exp_q.push_back('0);
      end
      for (int f = 0; f < flush_words(v.depth); f++) exp_q.push_back('0);
      exp_total = exp_q.size();
      budget    = 4 * exp_total + 64;

      ROW_LEN  = CW'(v.row_len);
      NUM_ROWS = CW'(v.num_rows);
      PAD      = 2'(v.pad);
      DEPTH    = CW'(v.depth);
      START    = 1'b1;
      IN_VALID = 1'b0;

      while (!done && cyc < budget) begin
         @(negedge CLK);
         cyc++;
         START    = (v.mid_start != 0 && cyc == 6);
         ROW_LEN  = CW'($urandom());
         NUM_ROWS = CW'($urandom());
         PAD      = 2'($urandom());
         DEPTH    = CW'($urandom());

         if (OUT_VALID) begin
            seen++;
            if (first < 0) first = cyc;
            if (exp_q.size() == 0) begin
               check("word_overrun", 64'(seen), 64'(exp_total));
            end else begin
               w = exp_q.pop_front();
               check("out_d", 64'(OUT_D), 64'(w));
               check("done_pos", 64'(DONE), 64'(exp_q.size() == 0));
            end
            if (DONE) done = 1;
         end else begin
            check("done_no_valid", 64'(DONE), 64'(0));
         end

         if (done) begin
            START    = 1'b0;
            IN_VALID = 1'b0;
            check("busy_at_done", 64'(BUSY), 64'(0));
            check("frame_words", 64'(seen), 64'(v.exp_row_words + flush_words(v.depth)));
            if (v.rand_valid == 0) begin
               check("gapless", 64'(cyc - first + 1), 64'(exp_total));
               check("ready_cycles", 64'(ready_cyc), 64'(n_data));
            end
         end else begin
            IN_VALID = src_q.size() != 0 && (v.rand_valid == 0 || $urandom_range(0, 3) != 0);
            IN_D     = IN_VALID ? src_q[0] : rand_word();
            if (IN_READY) ready_cyc++;
            if (IN_VALID && IN_READY) void'(src_q.pop_front());
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL frame_timeout got=%0d words exp=%0d", seen, exp_total);
      end
      START    = 1'b0;
      IN_VALID = 1'b0;
   endtask

   task automatic stall_seq();
      logic [WIDTH-1:0] a, b, c, d;
      a = rand_word(); b = rand_word(); c = rand_word(); d = rand_word();
      ROW_LEN = CW'(3); NUM_ROWS = '0; PAD = 2'd0; DEPTH = '0;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("stall_ready0", 64'(IN_READY), 64'(1));
      IN_VALID = 1'b1; IN_D = a;
      @(negedge CLK);
      check("stall_v1", 64'(OUT_VALID), 64'(1));
      check("stall_d1", 64'(OUT_D), 64'(a));
      IN_VALID = 1'b0; IN_D = rand_word();
      @(negedge CLK);
      check("stall_v2", 64'(OUT_VALID), 64'(0));
      check("stall_hold", 64'(OUT_D), 64'(a));
      check("stall_ready2", 64'(IN_READY), 64'(1));
      IN_D = rand_word();
      @(negedge CLK);
      check("stall_v3", 64'(OUT_VALID), 64'(0));
      check("stall_ready3", 64'(IN_READY), 64'(1));
      IN_VALID = 1'b1; IN_D = b;
      @(negedge CLK);
      check("stall_v4", 64'(OUT_VALID), 64'(1));
      check("stall_d4", 64'(OUT_D), 64'(b));
      IN_D = c;
      @(negedge CLK);
      check("stall_d5", 64'(OUT_D), 64'(c));
      IN_D = d;
      @(negedge CLK);
      IN_VALID = 1'b0;
      check("stall_d6", 64'(OUT_D), 64'(d));
`ifdef SPIKE_ROW_TX_FLUSH_EN
      check("stall_done6", 64'(DONE), 64'(0));
      @(negedge CLK);
      check("stall_flush_v", 64'(OUT_VALID), 64'(1));
      check("stall_flush_d", 64'(OUT_D), 64'(0));
`endif
      check("stall_done", 64'(DONE), 64'(1));
      check("stall_busy", 64'(BUSY), 64'(0));
   endtask

   task automatic rst_seq();
      bit seen_ready = 0;
      bit hit = 0;
      ROW_LEN = CW'(1); NUM_ROWS = CW'(1); PAD = 2'd2; DEPTH = CW'(3);
      START = 1'b1;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge CLK);
         START    = 1'b0;
         IN_VALID = 1'b1;
         IN_D     = rand_word();
         if (IN_READY) seen_ready = 1;
         else if (seen_ready) hit = 1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL rst_pad_r_timeout got=no_pad_r exp=pad_r");
      end
      RST = 1'b1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      check("rst_out_valid", 64'(OUT_VALID), 64'(0));
      check("rst_busy", 64'(BUSY), 64'(0));
      check("rst_done", 64'(DONE), 64'(0));
      check("rst_out_d", 64'(OUT_D), 64'(0));
      check("rst_ready", 64'(IN_READY), 64'(0));
      RST = 1'b0;
   endtask

   initial begin
      //          row_len num_rows pad depth rand seq mid exp_row_words
      vecs[0] = '{3,   1, 0, 2,   0, 1, 0, 8};
      vecs[1] = '{1,   1, 2, 3,   0, 0, 0, 12};
      vecs[2] = '{4,   2, 1, 0,   1, 0, 1, 21};
      vecs[3] = '{0,   0, 0, 0,   0, 0, 0, 1};
      vecs[4] = '{2,   3, 3, 5,   1, 0, 1, 36};
      vecs[5] = '{511, 0, 3, 7,   0, 0, 1, 518};
      vecs[6] = '{7,   1, 1, 511, 0, 0, 0, 20};

      RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_D = '0;
      ROW_LEN = '0; NUM_ROWS = '0; PAD = 2'd0; DEPTH = '0;
      repeat (3) @(negedge CLK);
      check("reset_out_valid", 64'(OUT_VALID), 64'(0));
      check("reset_out_d", 64'(OUT_D), 64'(0));
      check("reset_done", 64'(DONE), 64'(0));
      check("reset_busy", 64'(BUSY), 64'(0));
      check("reset_ready", 64'(IN_READY), 64'(0));
      RST = 1'b0;
      @(negedge CLK);

      stall_seq();
      for (int i = 0; i < 7; i++) run_frame(vecs[i]);
      rst_seq();
      run_frame(vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
